// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction sequencer: opcode encodings on the
// low four opcode bits and the controller state encoding.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_READ   = 4'b0011;
  localparam logic [3:0] OP_ALU_LO = 4'b0100;
  localparam logic [3:0] OP_ALU_HI = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/op_decode.sv
// Combinational instruction classifier.
// Ports:
//   opcode     : opcode field of the latched instruction
//   sel        : register-select field of the latched instruction
//   is_nop/is_load/is_read/is_alu/is_illegal : one-hot class of the instruction
module op_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int SEL_W    = 2,
  parameter int NUM_REGS = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [SEL_W-1:0]    sel,
  output logic                is_nop,
  output logic                is_load,
  output logic                is_read,
  output logic                is_alu,
  output logic                is_illegal
);

  logic [3:0] op_lo;
  logic       upper_nz;
  logic       sel_ok;

  assign op_lo  = opcode[3:0];
  assign sel_ok = (32'(sel) < NUM_REGS);

  // Opcodes are only defined on the low four bits; anything above must be zero.
  if (OPCODE_W > 4) begin : g_hi
    assign upper_nz = |opcode[OPCODE_W-1:4];
  end else begin : g_no_hi
    assign upper_nz = 1'b0;
  end

  always_comb begin
    is_nop     = 1'b0;
    is_load    = 1'b0;
    is_read    = 1'b0;
    is_alu     = 1'b0;
    is_illegal = 1'b0;
    if (upper_nz) begin
      is_illegal = 1'b1;
    end else begin
      case (op_lo)
        OP_NOP:  is_nop = 1'b1;
        OP_LOAD: begin
          if (sel_ok) is_load    = 1'b1;
          else        is_illegal = 1'b1;
        end
        OP_READ: is_read = 1'b1;
        default: begin
          if (op_lo >= OP_ALU_LO && op_lo <= OP_ALU_HI) is_alu     = 1'b1;
          else                                          is_illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle instruction sequencer. Accepts one instruction per handshake,
// issues a single-cycle strobe for it, and for ALU ops waits for alu_done
// (bounded by a watchdog) before pulsing write-back.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   instr_valid/instr : incoming instruction {opcode, sel}
//   instr_ready       : high in IDLE
//   load_en           : one-hot operand-register load strobe
//   read_en, rd_sel   : readout strobe and register index
//   alu_start, alu_op : ALU issue strobe and latched opcode
//   alu_done          : ALU completion pulse
//   wb_en             : result write-back strobe
//   busy              : !instr_ready
//   err_illegal, err_timeout : sticky error flags, cleared by err_clr
module seq_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int SEL_W    = 2,
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  input  logic [OPCODE_W+SEL_W-1:0] instr,
  output logic                      instr_ready,
  output logic [NUM_REGS-1:0]       load_en,
  output logic                      read_en,
  output logic [SEL_W-1:0]          rd_sel,
  output logic                      alu_start,
  output logic [OPCODE_W-1:0]       alu_op,
  input  logic                      alu_done,
  output logic                      wb_en,
  output logic                      busy,
  output logic                      err_illegal,
  output logic                      err_timeout,
  input  logic                      err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                      state, state_d;
  logic [OPCODE_W+SEL_W-1:0]   instr_q;
  logic [CNT_W-1:0]            cnt, cnt_d;
  logic                        set_ill, set_to;
  logic                        is_nop, is_load, is_read, is_alu, is_illegal;
  logic [OPCODE_W-1:0]         opcode_q;
  logic [SEL_W-1:0]            sel_q;
  logic                        issue;

  assign opcode_q = instr_q[OPCODE_W+SEL_W-1:SEL_W];
  assign sel_q    = instr_q[SEL_W-1:0];

  op_decode #(
    .OPCODE_W (OPCODE_W),
    .SEL_W    (SEL_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .opcode     (opcode_q),
    .sel        (sel_q),
    .is_nop     (is_nop),
    .is_load    (is_load),
    .is_read    (is_read),
    .is_alu     (is_alu),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      instr_q     <= '0;
      cnt         <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (instr_valid && instr_ready) instr_q <= instr;
      // A set event outranks a clear in the same cycle.
      err_illegal <= set_ill | (err_illegal & ~err_clr);
      err_timeout <= set_to  | (err_timeout & ~err_clr);
    end
  end

  // The counter holds cycles elapsed since alu_start, with the issue cycle
  // itself counted as the first, so the last WAIT cycle is where it reaches
  // TIMEOUT-1 and the flag lands TIMEOUT cycles after alu_start.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    set_ill = 1'b0;
    set_to  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instr_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        set_ill = is_illegal;
        if (is_alu) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (alu_done) begin
          state_d = ST_DONE;
        end else if (cnt == CNT_LAST) begin
          set_to  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue       = (state == ST_ISSUE);
  assign instr_ready = (state == ST_IDLE);
  assign busy        = ~instr_ready;
  assign read_en     = issue & is_read;
  assign rd_sel      = sel_q;
  assign alu_start   = issue & is_alu;
  assign alu_op      = opcode_q;
  assign wb_en       = (state == ST_DONE);

  always_comb begin
    load_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      load_en[i] = issue & is_load & (sel_q == SEL_W'(i));
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller. A second instance with NUM_REGS=3
// shares the same stimulus and covers the out-of-range LOAD select.
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [5:0] instr;
  logic       alu_done;
  logic       err_clr;

  logic       instr_ready, read_en, alu_start, wb_en, busy, err_illegal, err_timeout;
  logic [3:0] load_en;
  logic [1:0] rd_sel;
  logic [3:0] alu_op;

  logic       instr_ready3, read_en3, alu_start3, wb_en3, busy3, err_illegal3, err_timeout3;
  logic [2:0] load_en3;
  logic [1:0] rd_sel3;
  logic [3:0] alu_op3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_controller #(.OPCODE_W(4), .SEL_W(2), .NUM_REGS(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .load_en(load_en), .read_en(read_en),
    .rd_sel(rd_sel), .alu_start(alu_start), .alu_op(alu_op),
    .alu_done(alu_done), .wb_en(wb_en), .busy(busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  seq_controller #(.OPCODE_W(4), .SEL_W(2), .NUM_REGS(3), .TIMEOUT(16)) dut3 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready3), .load_en(load_en3), .read_en(read_en3),
    .rd_sel(rd_sel3), .alu_start(alu_start3), .alu_op(alu_op3),
    .alu_done(alu_done), .wb_en(wb_en3), .busy(busy3),
    .err_illegal(err_illegal3), .err_timeout(err_timeout3), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_quiet(input string tag);
    check({tag, " ready"},   32'(instr_ready), 32'd1);
    check({tag, " busy"},    32'(busy),        32'd0);
    check({tag, " load_en"}, 32'(load_en),     32'd0);
    check({tag, " read_en"}, 32'(read_en),     32'd0);
    check({tag, " alu_st"},  32'(alu_start),   32'd0);
    check({tag, " wb_en"},   32'(wb_en),       32'd0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; alu_done = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_idle_quiet("rst");
    check("rst err_ill", 32'(err_illegal), 32'd0);
    check("rst err_to",  32'(err_timeout), 32'd0);
    check("rst rd_sel",  32'(rd_sel),      32'd0);
    check("rst alu_op",  32'(alu_op),      32'd0);

    // LOAD sel=2
    instr_valid = 1'b1; instr = 6'b0001_10;
    tick();                                   // k+1
    instr_valid = 1'b0;
    check("load load_en", 32'(load_en),     32'h4);
    check("load ready",   32'(instr_ready), 32'd0);
    check("load busy",    32'(busy),        32'd1);
    check("load read_en", 32'(read_en),     32'd0);
    tick();                                   // k+2
    check_idle_quiet("load k2");

    // READ sel=1 then back-to-back NOP with valid held
    instr_valid = 1'b1; instr = 6'b0011_01;
    tick();                                   // k+1
    check("read read_en", 32'(read_en), 32'd1);
    check("read rd_sel",  32'(rd_sel),  32'd1);
    check("read load_en", 32'(load_en), 32'd0);
    instr = 6'b0000_00;
    tick();                                   // k+2: NOP handshake
    check("nop ready k2", 32'(instr_ready), 32'd1);
    check("nop read k2",  32'(read_en),     32'd0);
    tick();                                   // k+3: NOP issue
    instr_valid = 1'b0;
    check("nop busy k3",   32'(busy),      32'd1);
    check("nop read k3",   32'(read_en),   32'd0);
    check("nop load k3",   32'(load_en),   32'd0);
    check("nop alu k3",    32'(alu_start), 32'd0);
    tick();
    check_idle_quiet("nop k4");

    // alu_done in IDLE is ignored
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check_idle_quiet("idle done");
    tick();
    check("idle done wb", 32'(wb_en), 32'd0);

    // ALU 0110, alu_done 3 cycles after alu_start
    instr_valid = 1'b1; instr = 6'b0110_00;
    tick();                                   // k+1
    instr_valid = 1'b0;
    check("alu start", 32'(alu_start), 32'd1);
    check("alu op",    32'(alu_op),    32'h6);
    tick();                                   // k+2
    check("alu k2 start", 32'(alu_start), 32'd0);
    check("alu k2 wb",    32'(wb_en),     32'd0);
    check("alu k2 busy",  32'(busy),      32'd1);
    tick();                                   // k+3
    check("alu k3 wb", 32'(wb_en), 32'd0);
    tick();                                   // k+4
    alu_done = 1'b1;
    check("alu k4 wb", 32'(wb_en), 32'd0);
    tick();                                   // k+5
    alu_done = 1'b0;
    check("alu k5 wb",    32'(wb_en),       32'd1);
    check("alu k5 ready", 32'(instr_ready), 32'd0);
    tick();                                   // k+6
    check_idle_quiet("alu k6");

    // ALU 0100 with no alu_done: timeout
    instr_valid = 1'b1; instr = 6'b0100_00;
    tick();                                   // k+1
    instr_valid = 1'b0;
    check("to start", 32'(alu_start), 32'd1);
    check("to op",    32'(alu_op),    32'h4);
    for (int j = 2; j <= 16; j++) begin
      tick();                                 // k+j
      check($sformatf("to k%0d err", j),  32'(err_timeout), 32'd0);
      check($sformatf("to k%0d busy", j), 32'(busy),        32'd1);
      check($sformatf("to k%0d wb", j),   32'(wb_en),       32'd0);
    end
    tick();                                   // k+17
    check("to k17 err",   32'(err_timeout), 32'd1);
    check("to k17 ready", 32'(instr_ready), 32'd1);
    check("to k17 wb",    32'(wb_en),       32'd0);
    tick();
    check("to sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to cleared", 32'(err_timeout), 32'd0);

    // Second timeout with err_clr on the setting edge
    instr_valid = 1'b1; instr = 6'b0100_00;
    tick();                                   // k+1
    instr_valid = 1'b0;
    for (int j = 2; j <= 15; j++) tick();     // k+15
    check("to2 k15 err", 32'(err_timeout), 32'd0);
    tick();                                   // k+16
    err_clr = 1'b1;
    tick();                                   // k+17
    err_clr = 1'b0;
    check("to2 set wins", 32'(err_timeout), 32'd1);
    check("to2 ready",    32'(instr_ready), 32'd1);

    // Illegal opcode 1111
    instr_valid = 1'b1; instr = 6'b1111_00;
    tick();                                   // k+1
    instr_valid = 1'b0;
    check("ill load_en", 32'(load_en),   32'd0);
    check("ill read_en", 32'(read_en),   32'd0);
    check("ill alu",     32'(alu_start), 32'd0);
    check("ill err k1",  32'(err_illegal), 32'd0);
    tick();                                   // k+2
    check("ill err",     32'(err_illegal),  32'd1);
    check("ill err3",    32'(err_illegal3), 32'd1);
    check("ill ready",   32'(instr_ready),  32'd1);
    check("ill to kept", 32'(err_timeout),  32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ill clr",  32'(err_illegal),  32'd0);
    check("ill clr3", 32'(err_illegal3), 32'd0);

    // LOAD sel=3: legal with 4 registers, illegal with 3
    instr_valid = 1'b1; instr = 6'b0001_11;
    tick();                                   // k+1
    instr_valid = 1'b0;
    check("ld3 load_en",  32'(load_en),  32'h8);
    check("ld3 load_en3", 32'(load_en3), 32'h0);
    tick();                                   // k+2
    check("ld3 err",  32'(err_illegal),  32'd0);
    check("ld3 err3", 32'(err_illegal3), 32'd1);

    // Subsequent legal LOAD sel=1
    instr_valid = 1'b1; instr = 6'b0001_01;
    tick();
    instr_valid = 1'b0;
    check("ld1 load_en",  32'(load_en),  32'h2);
    check("ld1 load_en3", 32'(load_en3), 32'h2);
    tick();
    check("ld1 err3 sticky", 32'(err_illegal3), 32'd1);

    // Reset while in WAIT (err_timeout still set from before)
    instr_valid = 1'b1; instr = 6'b0101_10;
    tick();                                   // k+1
    instr_valid = 1'b0;
    check("rw start", 32'(alu_start), 32'd1);
    tick();                                   // k+2 in WAIT
    check("rw busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_quiet("rw");
    check("rw alu_op",  32'(alu_op),       32'd0);
    check("rw rd_sel",  32'(rd_sel),       32'd0);
    check("rw err_to",  32'(err_timeout),  32'd0);
    check("rw err_il3", 32'(err_illegal3), 32'd0);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check("rw late wb", 32'(wb_en), 32'd0);
    tick();
    check("rw late wb2", 32'(wb_en), 32'd0);
    check("rw ready",    32'(instr_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
